// File: rtl/axi_mem_master_if.sv
// Purpose: signal bundle between a CPU-side requester, the axi_mem_master
//          bridge and a 64-bit AXI memory slave.
// Modports:
//   master - the bridge's view. It takes CPU requests and drives AXI AR/AW/W,
//            R ready and B ready. It returns CPU responses.
//   slave  - the environment's view. It is the CPU requester plus the AXI slave.
// Signal groups: req_* (CPU request), resp_* (CPU response), axi_ar*, axi_r*,
//                axi_aw*, axi_w*, axi_b* (AXI4 channels, single-beat use).
interface axi_mem_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic [2:0]  req_size;

    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic [31:0] axi_araddr;
    logic        axi_arvalid;
    logic [3:0]  axi_arid;
    logic [7:0]  axi_arlen;
    logic [2:0]  axi_arsize;
    logic [1:0]  axi_arburst;
    logic        axi_arready;

    logic [63:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rvalid;
    logic        axi_rlast;
    logic [3:0]  axi_rid;
    logic        axi_rready;

    logic [31:0] axi_awaddr;
    logic        axi_awvalid;
    logic [3:0]  axi_awid;
    logic [7:0]  axi_awlen;
    logic [2:0]  axi_awsize;
    logic [1:0]  axi_awburst;
    logic        axi_awready;
    logic [63:0] axi_wdata;
    logic [7:0]  axi_wstrb;
    logic        axi_wvalid;
    logic        axi_wlast;
    logic        axi_wready;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic [3:0]  axi_bid;
    logic        axi_bready;

    modport master (
        input  req_valid, req_wen, req_addr, req_wdata, req_wmask, req_size,
        output req_ready,
        input  resp_ready,
        output resp_valid, resp_rdata, resp_err,
        output axi_araddr, axi_arvalid, axi_arid, axi_arlen, axi_arsize, axi_arburst,
        input  axi_arready,
        input  axi_rdata, axi_rresp, axi_rvalid, axi_rlast, axi_rid,
        output axi_rready,
        output axi_awaddr, axi_awvalid, axi_awid, axi_awlen, axi_awsize, axi_awburst,
        input  axi_awready,
        output axi_wdata, axi_wstrb, axi_wvalid, axi_wlast,
        input  axi_wready,
        input  axi_bresp, axi_bvalid, axi_bid,
        output axi_bready
    );

    modport slave (
        output req_valid, req_wen, req_addr, req_wdata, req_wmask, req_size,
        input  req_ready,
        output resp_ready,
        input  resp_valid, resp_rdata, resp_err,
        input  axi_araddr, axi_arvalid, axi_arid, axi_arlen, axi_arsize, axi_arburst,
        output axi_arready,
        output axi_rdata, axi_rresp, axi_rvalid, axi_rlast, axi_rid,
        input  axi_rready,
        input  axi_awaddr, axi_awvalid, axi_awid, axi_awlen, axi_awsize, axi_awburst,
        output axi_awready,
        input  axi_wdata, axi_wstrb, axi_wvalid, axi_wlast,
        output axi_wready,
        output axi_bresp, axi_bvalid, axi_bid,
        input  axi_bready
    );
endinterface

// File: rtl/axi_mem_master.sv
// Purpose: bridge from a simple 32-bit CPU load/store port to a 64-bit AXI4
//          memory slave. Only one single-beat transaction is in flight at a time.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous, active-high reset
//   bus  - axi_mem_master_if.master (CPU request/response plus AXI AR/R/AW/W/B)
// Parameters:
//   AXI_ID  - ID driven on ARID/AWID and expected back on RID/BID
//   TIMEOUT - response wait limit in cycles (timeout build only)
// Optional feature: define AXI_MEM_MASTER_TIMEOUT_EN to compile the response
//   timeout. In the default build the bridge waits indefinitely for the slave.
module axi_mem_master #(
    parameter logic [3:0] AXI_ID  = 4'h0,
    parameter int         TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    axi_mem_master_if.master         bus
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP,
        RESP
    } state_t;

    state_t      state_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wmask_q;
    logic [2:0]  size_q;
    logic        arvalid_q;
    logic        rready_q;
    logic        awvalid_q;
    logic        wvalid_q;
    logic        bready_q;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;

`ifdef AXI_MEM_MASTER_TIMEOUT_EN
    logic [31:0] tmo_q;
`else
    wire  [31:0] unused_timeout = TIMEOUT;
`endif

    // req_ready is decoded from the registered state. It is masked by rst so it
    // reads 0 while reset is held and 1 as soon as reset is released.
    assign bus.req_ready   = (state_q == IDLE) && !rst;

    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_rdata  = resp_rdata_q;
    assign bus.resp_err    = resp_err_q;

    // All AXI payload comes from latched request registers. It stays stable
    // while the valids are high and never depends directly on req_*.
    assign bus.axi_araddr  = addr_q;
    assign bus.axi_arvalid = arvalid_q;
    assign bus.axi_arid    = AXI_ID;
    assign bus.axi_arlen   = 8'd0;
    assign bus.axi_arsize  = size_q;
    assign bus.axi_arburst = 2'b01;
    assign bus.axi_rready  = rready_q;

    assign bus.axi_awaddr  = addr_q;
    assign bus.axi_awvalid = awvalid_q;
    assign bus.axi_awid    = AXI_ID;
    assign bus.axi_awlen   = 8'd0;
    assign bus.axi_awsize  = size_q;
    assign bus.axi_awburst = 2'b01;
    assign bus.axi_wdata   = {wdata_q, wdata_q};
    assign bus.axi_wstrb   = addr_q[2] ? {wmask_q, 4'h0} : {4'h0, wmask_q};
    assign bus.axi_wvalid  = wvalid_q;
    assign bus.axi_wlast   = 1'b1;
    assign bus.axi_bready  = bready_q;

    // Main FSM with registered handshake outputs. Slave response signals are
    // sampled only in their own wait states, so stray beats cannot be captured.
    // AW and W are tracked separately. The write request completes once each
    // valid has either already dropped or is accepted this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            wmask_q      <= 4'd0;
            size_q       <= 3'd0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
`ifdef AXI_MEM_MASTER_TIMEOUT_EN
            tmo_q        <= 32'd0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        wmask_q <= bus.req_wmask;
                        size_q  <= bus.req_size;
                        if (bus.req_wen) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= WR_REQ;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= RD_ADDR;
                        end
                    end
                end
                RD_ADDR: begin
                    if (bus.axi_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (bus.axi_rvalid) begin
                        rready_q     <= 1'b0;
                        resp_rdata_q <= addr_q[2] ? bus.axi_rdata[63:32] : bus.axi_rdata[31:0];
                        resp_err_q   <= (bus.axi_rresp != 2'b00) || (bus.axi_rid != AXI_ID)
                                        || !bus.axi_rlast;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end
                end
                WR_REQ: begin
                    if (awvalid_q && bus.axi_awready) awvalid_q <= 1'b0;
                    if (wvalid_q && bus.axi_wready)   wvalid_q  <= 1'b0;
                    if ((!awvalid_q || bus.axi_awready) && (!wvalid_q || bus.axi_wready)) begin
                        bready_q <= 1'b1;
                        state_q  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (bus.axi_bvalid) begin
                        bready_q     <= 1'b0;
                        resp_rdata_q <= 32'd0;
                        resp_err_q   <= (bus.axi_bresp != 2'b00) || (bus.axi_bid != AXI_ID);
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

`ifdef AXI_MEM_MASTER_TIMEOUT_EN
            // The counter runs through every AXI wait state. On its last count
            // it overrides whatever the case above chose and reports an error.
            if (state_q == RD_ADDR || state_q == RD_DATA ||
                state_q == WR_REQ  || state_q == WR_RESP) begin
                if (tmo_q == 32'(TIMEOUT - 1)) begin
                    tmo_q        <= 32'd0;
                    arvalid_q    <= 1'b0;
                    rready_q     <= 1'b0;
                    awvalid_q    <= 1'b0;
                    wvalid_q     <= 1'b0;
                    bready_q     <= 1'b0;
                    resp_rdata_q <= 32'd0;
                    resp_err_q   <= 1'b1;
                    resp_valid_q <= 1'b1;
                    state_q      <= RESP;
                end else begin
                    tmo_q <= tmo_q + 32'd1;
                end
            end else begin
                tmo_q <= 32'd0;
            end
`endif
        end
    end

endmodule
